// File: rtl/block_serial_subtractor.sv
// Block-serial subtractor: diff = a - b, computed as a + ~b + 1 one 4-bit
// carry-lookahead block per clock, least significant block first. Operands
// shift right by one nibble per step and result nibbles shift in from the top,
// so every step works on bit positions [3:0] and no wide nibble mux is needed.
module block_serial_subtractor #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int N     = WIDTH / 4;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
         $error("block_serial_subtractor: WIDTH must be a positive multiple of 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   // Block datapath signals
   logic [3:0]       an, bn, g, p, cy, sum;
   logic             cout;
   logic [WIDTH-1:0] diff_shift;

   // One 4-bit lookahead block on the low nibble of the shifted operands
   always_comb begin
      an = a_q[3:0];
      bn = ~b_q[3:0];
      g  = an & bn;
      p  = an | bn;
      cy[0] = c_q;
      cy[1] = g[0] | (p[0] & c_q);
      cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
      cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c_q);
      cout  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c_q);
      sum   = an ^ bn ^ cy;
      diff_shift = (diff_q >> 4) | (WIDTH'(sum) << (WIDTH - 4));
   end

   // Next-state and next-data logic for the IDLE/RUN/DONE controller
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               state_d = RUN;
               a_d     = a;
               b_d     = b;
               cnt_d   = '0;
               c_d     = 1'b1;
            end
         end
         RUN: begin
            a_d    = a_q >> 4;
            b_d    = b_q >> 4;
            c_d    = cout;
            diff_d = diff_shift;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               // Last block: a_q/b_q[3] are now the operand sign bits
               state_d = DONE;
               cnt_d   = '0;
               bout_d  = ~cout;
               ovf_d   = (a_q[3] != b_q[3]) && (sum[3] != a_q[3]);
               zero_d  = (diff_shift == '0);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and result registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         c_q     <= 1'b1;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   // Operand shift registers; only meaningful while an operation is running
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign in_ready  = (state_q == IDLE) && rst_n;
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Directed bench for block_serial_subtractor (WIDTH=32).
module tb_block_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        bout, ovf, zero;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic        bo;
      logic        ov;
      logic        z;
   } vec_t;

   vec_t vecs [8];

   block_serial_subtractor #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
   endtask

   // Launch one operation, check latency, results and return to IDLE
   task automatic run_op(input vec_t v, input string nm);
      int lat;
      @(negedge clk);
      a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b0;
      chk({nm, " in_ready_idle"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom; b = $urandom;
      chk({nm, " in_ready_run"}, 32'(in_ready), 32'd0);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!out_valid && lat < 20);
      chk({nm, " latency"}, 32'(lat), 32'd8);
      chk({nm, " diff"}, diff, v.d);
      chk({nm, " bout"}, 32'(bout), 32'(v.bo));
      chk({nm, " ovf"},  32'(ovf),  32'(v.ov));
      chk({nm, " zero"}, 32'(zero), 32'(v.z));
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({nm, " in_ready_after"}, 32'(in_ready), 32'd1);
      chk({nm, " out_valid_after"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      vec_t v;
      logic ok_v, ok_r, ok_d;
      logic [31:0] d_hold;

      vecs[0] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h1E1E_1E1F, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset in_ready", 32'(in_ready), 32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset diff", diff, 32'd0);
      chk("reset flags", {29'd0, bout, ovf, zero}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("reset release in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: hold result for 20 cycles with in_valid toggling
      @(negedge clk);
      a = 32'h0000_0100; b = 32'h0000_0001; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("bp out_valid start", 32'(out_valid), 32'd1);
      d_hold = diff;
      ok_v = 1'b1; ok_r = 1'b1; ok_d = 1'b1;
      for (int c = 0; c < 20; c++) begin
         in_valid = c[0];
         a = $urandom; b = $urandom;
         @(posedge clk);
         @(negedge clk);
         if (out_valid !== 1'b1) ok_v = 1'b0;
         if (in_ready !== 1'b0) ok_r = 1'b0;
         if (diff !== d_hold || bout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) ok_d = 1'b0;
      end
      chk("bp hold diff value", d_hold, 32'h0000_00FF);
      chk("bp out_valid held", 32'(ok_v), 32'd1);
      chk("bp in_ready low", 32'(ok_r), 32'd1);
      chk("bp outputs stable", 32'(ok_d), 32'd1);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp in_ready after handshake", 32'(in_ready), 32'd1);
      chk("bp out_valid after handshake", 32'(out_valid), 32'd0);

      // Reset in the middle of RUN (cnt=3) discards the operation
      a = 32'h0000_0100; b = 32'h0000_0001; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrun reset in_ready", 32'(in_ready), 32'd1);
      ok_v = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid !== 1'b0) ok_v = 1'b0;
      end
      chk("midrun reset no output", 32'(ok_v), 32'd1);
      chk("midrun reset diff cleared", diff, 32'd0);
      v = vecs[7];
      run_op(v, "post_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
